// File: rtl/hdc_sram_read_scheduler_pkg.sv
// Shared constants for the HDC SRAM read scheduler: hypervector width, bank indices, FSM encodings.
package hdc_sram_read_scheduler_pkg;

  localparam int unsigned HV_DIMENSION = 64;

  localparam int unsigned NUM_BANKS = 3;
  localparam int unsigned BANK_IM   = 0;
  localparam int unsigned BANK_NEG  = 1;
  localparam int unsigned BANK_POS  = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  typedef logic [NUM_BANKS-1:0] bank_mask_t;

  // Index width needed to name one of n requesters (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hdc_rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting index at or after the pointer.
// Purely combinational; the owner keeps the pointer register.
module hdc_rr_arbiter
  import hdc_sram_read_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [PTR_W-1:0]   idx_c,
  output logic               any_c
);

  // Scan requesters starting at the pointer, wrapping once around.
  always_comb begin
    int unsigned j;
    j       = 0;
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr_i) + k) % NUM_REQ;
      if (!any_c && req_i[PTR_W'(j)]) begin
        grant_c[PTR_W'(j)] = 1'b1;
        idx_c              = PTR_W'(j);
        any_c              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdc_sram_read_scheduler.sv
// Shares the IM / projM_neg / projM_pos SRAM read ports between NUM_REQ encoder requesters.
// One burst at a time: one address issued to all three banks, words collected, triple delivered.
module hdc_sram_read_scheduler
  import hdc_sram_read_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = HV_DIMENSION
) (
  input  logic                          Clk_CI,
  input  logic                          Reset_RI,
  input  logic [NUM_REQ-1:0]            ReqValid_SI,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqBase_DI,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  ReqLen_DI,
  output logic [NUM_REQ-1:0]            ReqGrant_SO,
  output logic [NUM_REQ-1:0]            ReqDone_SO,
  output logic [2:0]                    SramValid_SO,
  input  logic [2:0]                    SramReady_SI,
  output logic [ADDR_WIDTH-1:0]         SramAddr_DO,
  input  logic [2:0]                    SramRdValid_SI,
  input  logic [DATA_WIDTH-1:0]         IMData_DI,
  input  logic [DATA_WIDTH-1:0]         NegData_DI,
  input  logic [DATA_WIDTH-1:0]         PosData_DI,
  output logic [NUM_REQ-1:0]            DataValid_SO,
  input  logic [NUM_REQ-1:0]            DataReady_SI,
  output logic [DATA_WIDTH-1:0]         IMOut_DO,
  output logic [DATA_WIDTH-1:0]         NegOut_DO,
  output logic [DATA_WIDTH-1:0]         PosOut_DO,
  output logic                          Busy_SO,
  output logic                          Error_SO
);

  localparam int unsigned PTR_W = idx_width(NUM_REQ);

  logic [1:0]            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    sel_q, sel_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  zero_pend_q, zero_pend_d;
  bank_mask_t            sram_valid_q, sram_valid_d;
  bank_mask_t            acc_q, acc_d;
  bank_mask_t            got_q, got_d;
  logic [DATA_WIDTH-1:0] im_cap_q, im_cap_d;
  logic [DATA_WIDTH-1:0] neg_cap_q, neg_cap_d;
  logic [DATA_WIDTH-1:0] pos_cap_q, pos_cap_d;
  logic [DATA_WIDTH-1:0] im_out_q, im_out_d;
  logic [DATA_WIDTH-1:0] neg_out_q, neg_out_d;
  logic [DATA_WIDTH-1:0] pos_out_q, pos_out_d;
  logic [NUM_REQ-1:0]    data_valid_q, data_valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic                  rd_window;
  bank_mask_t            accept;
  bank_mask_t            take;

  hdc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (ReqValid_SI),
    .ptr_i   (ptr_q),
    .grant_c (arb_grant),
    .idx_c   (arb_idx),
    .any_c   (arb_any)
  );

  // Pick out the winning requester's base address and burst length.
  always_comb begin
    base_sel = '0;
    len_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        base_sel = ReqBase_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
        len_sel  = ReqLen_DI[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Bank command/response bookkeeping: accepts, legal captures, stray responses.
  always_comb begin
    rd_window = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    accept    = sram_valid_q & SramReady_SI;
    take      = SramRdValid_SI & acc_q & ~got_q & {NUM_BANKS{rd_window}};
  end

  // Scheduler next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    done_d       = '0;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    zero_pend_d  = 1'b0;
    sram_valid_d = sram_valid_q & ~accept;
    acc_d        = acc_q | accept;
    got_d        = got_q | take;
    im_cap_d     = take[BANK_IM]  ? IMData_DI  : im_cap_q;
    neg_cap_d    = take[BANK_NEG] ? NegData_DI : neg_cap_q;
    pos_cap_d    = take[BANK_POS] ? PosData_DI : pos_cap_q;
    im_out_d     = im_out_q;
    neg_out_d    = neg_out_q;
    pos_out_d    = pos_out_q;
    data_valid_d = data_valid_q;
    err_d        = err_q | (|(SramRdValid_SI & ~take));

    case (state_q)
      ST_IDLE: begin
        if (zero_pend_q) begin
          // Zero-length burst completes the cycle after its grant; no new grant meanwhile.
          done_d = sel_q;
        end else if (arb_any) begin
          grant_d = arb_grant;
          sel_d   = arb_grant;
          ptr_d   = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
          addr_d  = base_sel;
          rem_d   = len_sel;
          if (len_sel == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            sram_valid_d = '1;
            acc_d        = '0;
            got_d        = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (&acc_d) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (&got_d) begin
          state_d      = ST_DELIVER;
          data_valid_d = sel_q;
          im_out_d     = im_cap_d;
          neg_out_d    = neg_cap_d;
          pos_out_d    = pos_cap_d;
        end
      end
      ST_DELIVER: begin
        if (|(data_valid_q & DataReady_SI)) begin
          data_valid_d = '0;
          addr_d       = addr_q + ADDR_WIDTH'(1);
          rem_d        = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            done_d  = sel_q;
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_ISSUE;
            sram_valid_d = '1;
            acc_d        = '0;
            got_d        = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      sel_q        <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      zero_pend_q  <= 1'b0;
      sram_valid_q <= '0;
      acc_q        <= '0;
      got_q        <= '0;
      im_cap_q     <= '0;
      neg_cap_q    <= '0;
      pos_cap_q    <= '0;
      im_out_q     <= '0;
      neg_out_q    <= '0;
      pos_out_q    <= '0;
      data_valid_q <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      zero_pend_q  <= zero_pend_d;
      sram_valid_q <= sram_valid_d;
      acc_q        <= acc_d;
      got_q        <= got_d;
      im_cap_q     <= im_cap_d;
      neg_cap_q    <= neg_cap_d;
      pos_cap_q    <= pos_cap_d;
      im_out_q     <= im_out_d;
      neg_out_q    <= neg_out_d;
      pos_out_q    <= pos_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign ReqGrant_SO  = grant_q;
  assign ReqDone_SO   = done_q;
  assign SramValid_SO = sram_valid_q;
  assign SramAddr_DO  = addr_q;
  assign DataValid_SO = data_valid_q;
  assign IMOut_DO     = im_out_q;
  assign NegOut_DO    = neg_out_q;
  assign PosOut_DO    = pos_out_q;
  assign Busy_SO      = busy_q;
  assign Error_SO     = err_q;

endmodule

// File: tb/tb_hdc_sram_read_scheduler.sv
// Directed bench for hdc_sram_read_scheduler with a latency-programmable three-bank SRAM model.
module tb_hdc_sram_read_scheduler;
  import hdc_sram_read_scheduler_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = HV_DIMENSION;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_base;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]    grant, done, data_valid, dready;
  logic [2:0]       sram_valid, sram_rdy, stray, rdv;
  logic [2:0]       rdv_model = 3'b000;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    bank_data [3] = '{default: '0};
  logic [DW-1:0]    im_out, neg_out, pos_out;
  logic             busy, err;
  int               lat [3];

  assign rdv = rdv_model | stray;

  hdc_sram_read_scheduler #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)
  ) dut (
    .Clk_CI(clk), .Reset_RI(rst_n),
    .ReqValid_SI(req_valid), .ReqBase_DI(req_base), .ReqLen_DI(req_len),
    .ReqGrant_SO(grant), .ReqDone_SO(done),
    .SramValid_SO(sram_valid), .SramReady_SI(sram_rdy), .SramAddr_DO(sram_addr),
    .SramRdValid_SI(rdv),
    .IMData_DI(bank_data[0]), .NegData_DI(bank_data[1]), .PosData_DI(bank_data[2]),
    .DataValid_SO(data_valid), .DataReady_SI(dready),
    .IMOut_DO(im_out), .NegOut_DO(neg_out), .PosOut_DO(pos_out),
    .Busy_SO(busy), .Error_SO(err)
  );

  // Memory contents: distinct per bank and per address.
  function automatic logic [DW-1:0] word(input int b, input logic [AW-1:0] a);
    logic [7:0] t;
    t = 8'(b + 1);
    return DW'({t, 8'h5A, a, ~a, t ^ 8'hF0, a ^ 8'h3C, 8'hC3, a});
  endfunction

  // SRAM bank model: each accepted command returns its word lat[b] cycles later.
  int            cnt [3]   = '{0, 0, 0};
  logic [2:0]    pend      = 3'b000;
  logic [AW-1:0] paddr [3] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      rdv_model[b] <= 1'b0;
      if (pend[b]) begin
        if (cnt[b] <= 1) begin
          rdv_model[b] <= 1'b1;
          bank_data[b] <= word(b, paddr[b]);
          pend[b]      <= 1'b0;
        end else begin
          cnt[b] <= cnt[b] - 1;
        end
      end
      if (sram_valid[b] && sram_rdy[b]) begin
        if (lat[b] <= 1) begin
          rdv_model[b] <= 1'b1;
          bank_data[b] <= word(b, sram_addr);
        end else begin
          pend[b]  <= 1'b1;
          cnt[b]   <= lat[b] - 1;
          paddr[b] <= sram_addr;
        end
      end
    end
  end

  // Transaction monitor.
  int            cyc = 0;
  int            sv_cycles = 0;
  int            grant_log[$], gcyc_log[$], done_log[$], dcyc_log[$], deliv_sel[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] dim[$], dneg[$], dpos[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (grant[i]) begin grant_log.push_back(i); gcyc_log.push_back(cyc); end
        if (done[i])  begin done_log.push_back(i);  dcyc_log.push_back(cyc); end
      end
      if (sram_valid[0] && sram_rdy[0]) addr_log.push_back(sram_addr);
      if (sram_valid != 3'b000) sv_cycles <= sv_cycles + 1;
      if ((data_valid & dready) != '0) begin
        deliv_sel.push_back(int'(data_valid));
        dim.push_back(im_out);
        dneg.push_back(neg_out);
        dpos.push_back(pos_out);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_deliv(input string tag, input int n, input int sel, input logic [AW-1:0] a);
    chk({tag, "_sel"}, DW'(deliv_sel[n]), DW'(sel));
    chk({tag, "_im"},  dim[n],  word(0, a));
    chk({tag, "_neg"}, dneg[n], word(1, a));
    chk({tag, "_pos"}, dpos[n], word(2, a));
  endtask

  // One cycle; requesters drop their request once they see the grant.
  task automatic tick();
    @(negedge clk);
    req_valid = req_valid & ~grant;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_req(input int i, input int base, input int len);
    req_base[i*AW +: AW] = AW'(base);
    req_len[i*LW +: LW]  = LW'(len);
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_log.size() < target && k < budget) begin
      tick();
      k++;
    end
  endtask

  int d0, a0, v0, g0, s0, k;

  initial begin
    req_valid = '0; req_base = '0; req_len = '0;
    sram_rdy = 3'b111; stray = 3'b000; dready = '1;
    lat[0] = 1; lat[1] = 1; lat[2] = 1;
    run(3);

    // Reset values
    chk("rst_grant", DW'(grant), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_sram_valid", DW'(sram_valid), '0);
    chk("rst_addr", DW'(sram_addr), '0);
    chk("rst_data_valid", DW'(data_valid), '0);
    chk("rst_im_out", im_out, '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_err", DW'(err), '0);
    rst_n = 1'b1;
    run(2);

    // Req1 base 10 len 3
    d0 = done_log.size(); a0 = addr_log.size(); v0 = deliv_sel.size(); g0 = grant_log.size();
    set_req(1, 'h10, 3);
    wait_done(d0 + 1, 100);
    run(3);
    chk("t1_done_cnt", DW'(done_log.size()), DW'(d0 + 1));
    chk("t1_done_idx", DW'(done_log[d0]), DW'(1));
    chk("t1_grant_idx", DW'(grant_log[g0]), DW'(1));
    chk("t1_addr_cnt", DW'(addr_log.size()), DW'(a0 + 3));
    for (int i = 0; i < 3; i++) chk("t1_addr", DW'(addr_log[a0 + i]), DW'(AW'('h10 + i)));
    chk("t1_deliv_cnt", DW'(deliv_sel.size()), DW'(v0 + 3));
    for (int i = 0; i < 3; i++) chk_deliv("t1_word", v0 + i, 2, AW'('h10 + i));
    chk("t1_err", DW'(err), '0);

    // All three requesters at reset release, len 1 each; then RR wraps
    rst_n = 1'b0;
    tick();
    d0 = done_log.size(); v0 = deliv_sel.size(); g0 = grant_log.size();
    set_req(0, 'h20, 1); set_req(1, 'h30, 1); set_req(2, 'h40, 1);
    tick();
    rst_n = 1'b1;
    wait_done(d0 + 3, 200);
    run(2);
    chk("t2_grant0", DW'(grant_log[g0]), DW'(0));
    chk("t2_grant1", DW'(grant_log[g0 + 1]), DW'(1));
    chk("t2_grant2", DW'(grant_log[g0 + 2]), DW'(2));
    chk_deliv("t2_r0", v0, 1, 8'h20);
    chk_deliv("t2_r1", v0 + 1, 2, 8'h30);
    chk_deliv("t2_r2", v0 + 2, 4, 8'h40);
    set_req(0, 'h24, 1); set_req(2, 'h44, 1);
    wait_done(d0 + 5, 200);
    run(2);
    chk("t2_regrant0", DW'(grant_log[g0 + 3]), DW'(0));
    chk("t2_regrant2", DW'(grant_log[g0 + 4]), DW'(2));
    chk_deliv("t2_rr0", v0 + 3, 1, 8'h24);
    chk_deliv("t2_rr2", v0 + 4, 4, 8'h44);

    // Pos bank not ready for 5 cycles
    d0 = done_log.size(); v0 = deliv_sel.size();
    sram_rdy = 3'b011;
    set_req(0, 'h50, 1);
    k = 0;
    tick();
    while (sram_valid == 3'b000 && k < 10) begin tick(); k++; end
    chk("t3_first_issue", DW'(sram_valid), DW'(3'b111));
    chk("t3_first_addr", DW'(sram_addr), DW'(8'h50));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_pos_only", DW'(sram_valid), DW'(3'b100));
      chk("t3_addr_hold", DW'(sram_addr), DW'(8'h50));
      chk("t3_no_data", DW'(data_valid), '0);
    end
    sram_rdy = 3'b111;
    wait_done(d0 + 1, 50);
    run(2);
    chk("t3_deliv_cnt", DW'(deliv_sel.size()), DW'(v0 + 1));
    chk_deliv("t3_word", v0, 1, 8'h50);

    // Out-of-order bank returns: IM +3, neg +5, pos +1
    d0 = done_log.size(); v0 = deliv_sel.size();
    lat[0] = 3; lat[1] = 5; lat[2] = 1;
    set_req(2, 'h60, 1);
    wait_done(d0 + 1, 60);
    run(6);
    chk("t4_deliv_cnt", DW'(deliv_sel.size()), DW'(v0 + 1));
    chk_deliv("t4_word", v0, 4, 8'h60);
    chk("t4_err", DW'(err), '0);
    lat[0] = 1; lat[1] = 1; lat[2] = 1;

    // Address wrap
    d0 = done_log.size(); a0 = addr_log.size(); v0 = deliv_sel.size();
    set_req(0, 'hFE, 4);
    wait_done(d0 + 1, 100);
    run(2);
    chk("t5_addr0", DW'(addr_log[a0]), DW'(8'hFE));
    chk("t5_addr1", DW'(addr_log[a0 + 1]), DW'(8'hFF));
    chk("t5_addr2", DW'(addr_log[a0 + 2]), DW'(8'h00));
    chk("t5_addr3", DW'(addr_log[a0 + 3]), DW'(8'h01));
    chk_deliv("t5_wrap", v0 + 2, 1, 8'h00);
    chk("t5_deliv_cnt", DW'(deliv_sel.size()), DW'(v0 + 4));

    // Zero-length burst
    d0 = done_log.size(); v0 = deliv_sel.size(); g0 = grant_log.size(); s0 = sv_cycles;
    set_req(1, 'h33, 0);
    wait_done(d0 + 1, 20);
    run(2);
    chk("t6_grant", DW'(grant_log[g0]), DW'(1));
    chk("t6_done", DW'(done_log[d0]), DW'(1));
    chk("t6_done_lag", DW'(dcyc_log[d0] - gcyc_log[g0]), DW'(1));
    chk("t6_no_issue", DW'(sv_cycles), DW'(s0));
    chk("t6_no_deliv", DW'(deliv_sel.size()), DW'(v0));
    chk("t6_busy", DW'(busy), '0);

    // Requester stalls, then reset mid-burst, then a stray response
    dready = '0;
    set_req(0, 'h70, 2);
    k = 0;
    tick();
    while (data_valid == '0 && k < 30) begin tick(); k++; end
    run(10);
    chk("t7_hold_valid", DW'(data_valid), DW'(3'b001));
    chk("t7_hold_im", im_out, word(0, 8'h70));
    chk("t7_hold_pos", pos_out, word(2, 8'h70));
    chk("t7_busy", DW'(busy), DW'(1));
    d0 = done_log.size();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", DW'(data_valid), '0);
    chk("t7_rst_im", im_out, '0);
    chk("t7_rst_busy", DW'(busy), '0);
    chk("t7_rst_sv", DW'(sram_valid), '0);
    chk("t7_rst_done", DW'(done), '0);
    tick();
    rst_n = 1'b1;
    dready = '1;
    run(3);
    chk("t7_no_done", DW'(done_log.size()), DW'(d0));
    chk("t7_err_clear", DW'(err), '0);
    stray = 3'b010;
    tick();
    stray = 3'b000;
    tick();
    chk("t7_err_set", DW'(err), DW'(1));
    run(2);
    chk("t7_err_sticky", DW'(err), DW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
